// File: rtl/cv_reset_seq.sv
// rtl/cv_reset_seq.sv - staged reset sequencer for VDP/PSG/Z80 with POR synchroniser (optional CV_RESET_DEBOUNCE_EN)
module cv_reset_seq #(
  parameter int SYNC_STAGES  = 2,
  parameter int STRETCH_CYC  = 16,
  parameter int GAP_CYC      = 4,
  parameter int DEBOUNCE_CYC = 8
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clk_en_i,
  input  logic soft_req_i,
  input  logic hold_i,
  output logic rst_sync_n_o,
  output logic vdp_reset_n_o,
  output logic psg_reset_n_o,
  output logic cpu_reset_n_o,
  output logic busy_o,
  output logic done_o
);

  localparam int CNT_MAX = (STRETCH_CYC > GAP_CYC) ? STRETCH_CYC : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_REL_VDP,
    ST_REL_PSG,
    ST_REL_CPU,
    ST_RUN
  } state_t;

  // Reject parameter values the sequencer cannot honour.
  if (SYNC_STAGES < 2 || STRETCH_CYC < 1 || GAP_CYC < 1 || DEBOUNCE_CYC < 1) begin : g_bad_param
    $error("cv_reset_seq: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_q;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   vdp_q, vdp_d;
  logic                   psg_q, psg_d;
  logic                   cpu_q, cpu_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Async-assert / sync-deassert shift chain for the POR reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) sync_q <= '0;
    else            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_sync_n_o = sync_q[SYNC_STAGES-1];

`ifdef CV_RESET_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

  logic [DW-1:0] db_cnt_q;

  // Soft request asserts only after DEBOUNCE_CYC consecutive high samples; any low sample restarts the count.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      db_cnt_q <= '0;
      req_q    <= 1'b0;
    end else if (!soft_req_i) begin
      db_cnt_q <= '0;
      req_q    <= 1'b0;
    end else if (db_cnt_q == DB_LAST) begin
      req_q    <= 1'b1;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end
`else
  // Soft request is simply registered once, so a single-cycle pulse is enough to restart.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) req_q <= 1'b0;
    else            req_q <= soft_req_i;
  end
`endif

  // Sequencer state, tick counter and registered domain outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      vdp_q   <= 1'b0;
      psg_q   <= 1'b0;
      cpu_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vdp_q   <= vdp_d;
      psg_q   <= psg_d;
      cpu_q   <= cpu_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: restart dominates, otherwise count clk_en ticks through the staged releases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vdp_d   = vdp_q;
    psg_d   = psg_q;
    cpu_d   = cpu_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (rst_sync_n_o) begin
      if (req_q || hold_i) begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
        vdp_d   = 1'b0;
        psg_d   = 1'b0;
        cpu_d   = 1'b0;
        busy_d  = 1'b1;
      end else begin
        case (state_q)
          ST_ASSERT: begin
            if (clk_en_i) begin
              if (cnt_q == STRETCH_LAST) begin
                cnt_d   = '0;
                state_d = ST_REL_VDP;
                vdp_d   = 1'b1;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
          ST_REL_VDP: begin
            if (clk_en_i) begin
              if (cnt_q == GAP_LAST) begin
                cnt_d   = '0;
                state_d = ST_REL_PSG;
                psg_d   = 1'b1;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
          ST_REL_PSG: begin
            if (clk_en_i) begin
              if (cnt_q == GAP_LAST) begin
                cnt_d   = '0;
                state_d = ST_REL_CPU;
                cpu_d   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
          ST_REL_CPU: state_d = ST_RUN;
          ST_RUN:     state_d = ST_RUN;
          default: begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  assign vdp_reset_n_o = vdp_q;
  assign psg_reset_n_o = psg_q;
  assign cpu_reset_n_o = cpu_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_cv_reset_seq.sv
// tb/tb_cv_reset_seq.sv - self-checking bench for cv_reset_seq
module tb_cv_reset_seq;

`ifdef CV_RESET_DEBOUNCE_EN
  localparam int L = 8;
`else
  localparam int L = 1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clk_en = 1'b1;
  logic soft_req = 1'b0;
  logic hold = 1'b0;
  logic rst_sync_n, vdp_n, psg_n, cpu_n, busy, done;

  int edge_cnt = 0;
  int checks = 0;
  int errors = 0;
  int en_mode = 0;
  int en_base = 0;

  typedef struct {
    int          at;
    logic [5:0]  exp;
    string       name;
  } vec_t;

  vec_t sb[$];
  vec_t por_tab[9];
  vec_t soft_tab[10];
  vec_t clk3_tab[7];

  cv_reset_seq dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .clk_en_i      (clk_en),
    .soft_req_i    (soft_req),
    .hold_i        (hold),
    .rst_sync_n_o  (rst_sync_n),
    .vdp_reset_n_o (vdp_n),
    .psg_reset_n_o (psg_n),
    .cpu_reset_n_o (cpu_n),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [5:0] outs();
    return {rst_sync_n, vdp_n, psg_n, cpu_n, busy, done};
  endfunction

  function automatic vec_t mk(input int at, input logic [5:0] exp, input string name);
    vec_t v;
    v.at = at;
    v.exp = exp;
    v.name = name;
    return v;
  endfunction

  task automatic push(input int at, input logic [5:0] exp, input string name);
    sb.push_back(mk(at, exp, name));
  endtask

  // Advance n negedges, retiring every scoreboard entry due at the current edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= edge_cnt) begin
        vec_t e;
        e = sb.pop_front();
        checks++;
        if (e.at != edge_cnt || outs() !== e.exp) begin
          errors++;
          $display("FAIL %s: edge %0d got {sync,vdp,psg,cpu,busy,done}=%b, expected %b at edge %0d",
                   e.name, edge_cnt, outs(), e.exp, e.at);
        end
      end
      clk_en = (en_mode == 0) ? 1'b1 : (((edge_cnt + 1 - en_base) % 3) == 1);
    end
  endtask

  task automatic drain(input int max_edges);
    int n;
    n = 0;
    while (sb.size() > 0 && n < max_edges) begin
      step(1);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d expectations still pending at edge %0d", sb.size(), edge_cnt);
      sb.delete();
    end
  endtask

  initial begin
    int e0, x, r;

    por_tab[0] = mk(0,  6'b000010, "por_e0");
    por_tab[1] = mk(1,  6'b100010, "por_sync");
    por_tab[2] = mk(16, 6'b100010, "por_vdp_hold");
    por_tab[3] = mk(17, 6'b110010, "por_vdp_rel");
    por_tab[4] = mk(20, 6'b110010, "por_psg_hold");
    por_tab[5] = mk(21, 6'b111010, "por_psg_rel");
    por_tab[6] = mk(24, 6'b111010, "por_cpu_hold");
    por_tab[7] = mk(25, 6'b111101, "por_cpu_rel");
    por_tab[8] = mk(26, 6'b111100, "por_done_end");

    soft_tab[0] = mk(-1, 6'b111100, "soft_pre");
    soft_tab[1] = mk(0,  6'b100010, "soft_restart");
    soft_tab[2] = mk(15, 6'b100010, "soft_vdp_hold");
    soft_tab[3] = mk(16, 6'b110010, "soft_vdp_rel");
    soft_tab[4] = mk(19, 6'b110010, "soft_psg_hold");
    soft_tab[5] = mk(20, 6'b111010, "soft_psg_rel");
    soft_tab[6] = mk(23, 6'b111010, "soft_cpu_hold");
    soft_tab[7] = mk(24, 6'b111101, "soft_cpu_rel");
    soft_tab[8] = mk(25, 6'b111100, "soft_done_end");
    soft_tab[9] = mk(26, 6'b111100, "soft_run");

    clk3_tab[0] = mk(48, 6'b100010, "en3_vdp_hold");
    clk3_tab[1] = mk(49, 6'b110010, "en3_vdp_rel");
    clk3_tab[2] = mk(60, 6'b110010, "en3_psg_hold");
    clk3_tab[3] = mk(61, 6'b111010, "en3_psg_rel");
    clk3_tab[4] = mk(72, 6'b111010, "en3_cpu_hold");
    clk3_tab[5] = mk(73, 6'b111101, "en3_cpu_rel");
    clk3_tab[6] = mk(74, 6'b111100, "en3_done_end");

    // Reset state while reset_n is held low.
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (outs() !== 6'b000010) begin
      errors++;
      $display("FAIL reset_state: got %b, expected 000010", outs());
    end

    // POR release ahead of edge e0.
    reset_n = 1'b1;
    e0 = edge_cnt + 1;
    foreach (por_tab[i]) push(e0 + por_tab[i].at, por_tab[i].exp, por_tab[i].name);
    drain(60);
    step(2);

`ifdef CV_RESET_DEBOUNCE_EN
    // A request one sample short of the debounce length must not restart.
    x = edge_cnt;
    soft_req = 1'b1;
    push(x + 7,  6'b111100, "db7_end");
    push(x + 9,  6'b111100, "db7_after");
    push(x + 12, 6'b111100, "db7_late");
    step(7);
    soft_req = 1'b0;
    drain(20);
`endif

    // Soft request in RUN re-runs the whole sequence; rst_sync stays high.
    x = edge_cnt;
    r = x + L + 1;
    soft_req = 1'b1;
    foreach (soft_tab[i]) push(r + soft_tab[i].at, soft_tab[i].exp, soft_tab[i].name);
    step(L);
    soft_req = 1'b0;
    drain(60);
    step(2);

    // hold_i asserted for 100 cycles while in REL_PSG.
    x = edge_cnt;
    r = x + L + 1;
    soft_req = 1'b1;
    step(L);
    soft_req = 1'b0;
    step(22);
    hold = 1'b1;
    for (int k = 22; k <= 121; k++) push(r + k, 6'b100010, "hold_low");
    step(100);
    hold = 1'b0;
    push(r + 136, 6'b100010, "hold_vdp_wait");
    push(r + 137, 6'b110010, "hold_vdp_rel");
    drain(40);
    step(10);

    // Async reset in the middle of REL_VDP, checked before any clock edge.
    x = edge_cnt;
    r = x + L + 1;
    soft_req = 1'b1;
    step(L);
    soft_req = 1'b0;
    step(18);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 6'b000010) begin
      errors++;
      $display("FAIL async_reset_mid_vdp: got %b, expected 000010", outs());
    end

    // Re-release with clk_en on every third cycle.
    reset_n = 1'b1;
    en_mode = 1;
    en_base = edge_cnt + 1;
    clk_en = 1'b0;
    foreach (clk3_tab[i]) push(en_base + clk3_tab[i].at, clk3_tab[i].exp, clk3_tab[i].name);
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
